// File: rtl/btn_event_ctrl_if.sv
// Event port between the button controller and its consumer.
// A valid/ready handshake carries one event (button index plus type) per transfer.
interface btn_event_ctrl_if #(
  parameter int unsigned BtnW = 2
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [BtnW-1:0] evt_btn;
  logic [1:0]      evt_type;

  modport master (
    output evt_valid,
    output evt_btn,
    output evt_type,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_btn,
    input  evt_type,
    output evt_ready
  );
endinterface

// File: rtl/btn_event_ctrl.sv
// Front-panel push-button controller: shared sample tick, per-button debounce,
// press/release/long/repeat event FSMs and a round-robin event arbiter.
module btn_event_ctrl #(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned TICK_DIV     = 1000000,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_in,
  output logic                tick,
  output logic [NUM_BTN-1:0]  held,
  btn_event_ctrl_if.master    evt,
  output logic [NUM_BTN-1:0]  dropped,
  input  logic                clr_dropped
);

  localparam int unsigned BtnW  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int unsigned PreW  = $clog2(TICK_DIV);
  localparam int unsigned HcntW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RcntW = $clog2(REPEAT_TICKS + 1);

  localparam logic [PreW-1:0] PreReload = PreW'(TICK_DIV - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDown = 2'd1;
  localparam logic [1:0] StRpt  = 2'd2;

  localparam logic [1:0] EvPress   = 2'd0;
  localparam logic [1:0] EvRelease = 2'd1;
  localparam logic [1:0] EvLong    = 2'd2;
  localparam logic [1:0] EvRepeat  = 2'd3;

  // Front end: synchronizer, prescaler, debounce
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic               tick_q, tick_d;
  logic               fsm_en_q, fsm_en_d;
  logic [NUM_BTN-1:0] samp_q, samp_d;
  logic [NUM_BTN-1:0] held_q, held_d;
  logic [NUM_BTN-1:0] agree;

  // Per-button event FSMs
  logic [1:0]         state_q [NUM_BTN];
  logic [1:0]         state_d [NUM_BTN];
  logic [HcntW-1:0]   hcnt_q  [NUM_BTN];
  logic [HcntW-1:0]   hcnt_d  [NUM_BTN];
  logic [RcntW-1:0]   rcnt_q  [NUM_BTN];
  logic [RcntW-1:0]   rcnt_d  [NUM_BTN];
  logic [NUM_BTN-1:0] post_vld;
  logic [1:0]         post_type [NUM_BTN];

  // Pending slots, sticky drop flags, arbiter and output register
  logic [NUM_BTN-1:0] slot_vld_q, slot_vld_d;
  logic [1:0]         slot_type_q [NUM_BTN];
  logic [1:0]         slot_type_d [NUM_BTN];
  logic [NUM_BTN-1:0] drop;
  logic [NUM_BTN-1:0] dropped_q, dropped_d;
  logic [NUM_BTN-1:0] gnt_vec;
  logic               load_en;
  logic               found;
  logic [BtnW-1:0]    gnt_idx;
  logic [BtnW-1:0]    last_q, last_d;
  logic               evt_valid_q, evt_valid_d;
  logic [BtnW-1:0]    evt_btn_q, evt_btn_d;
  logic [1:0]         evt_type_q, evt_type_d;

  assign agree = ~(sync2_q ^ samp_q);

  always_comb begin : p_front
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    tick_d   = (pre_q == '0);
    pre_d    = tick_d ? PreReload : pre_q - 1'b1;
    fsm_en_d = tick_q;
    samp_d   = samp_q;
    held_d   = held_q;
    if (tick_q) begin
      samp_d = sync2_q;
      // A level is accepted only once two consecutive ticks agree on it
      held_d = (agree & sync2_q) | (~agree & held_q);
    end
  end

  always_comb begin : p_fsm
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]   = state_q[i];
      hcnt_d[i]    = hcnt_q[i];
      rcnt_d[i]    = rcnt_q[i];
      post_vld[i]  = 1'b0;
      post_type[i] = EvPress;
      if (fsm_en_q) begin
        case (state_q[i])
          StIdle: begin
            if (held_q[i]) begin
              post_vld[i]  = 1'b1;
              post_type[i] = EvPress;
              hcnt_d[i]    = '0;
              state_d[i]   = StDown;
            end
          end
          StDown: begin
            if (!held_q[i]) begin
              post_vld[i]  = 1'b1;
              post_type[i] = EvRelease;
              state_d[i]   = StIdle;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 1'b1;
              if (32'(hcnt_q[i]) + 32'd1 == LONG_TICKS) begin
                post_vld[i]  = 1'b1;
                post_type[i] = EvLong;
                rcnt_d[i]    = '0;
                state_d[i]   = StRpt;
              end
            end
          end
          StRpt: begin
            if (!held_q[i]) begin
              post_vld[i]  = 1'b1;
              post_type[i] = EvRelease;
              state_d[i]   = StIdle;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
              if (32'(rcnt_q[i]) + 32'd1 == REPEAT_TICKS) begin
                post_vld[i]  = 1'b1;
                post_type[i] = EvRepeat;
                rcnt_d[i]    = '0;
              end
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  // Search starts just after the last granted button, wrapping modulo NUM_BTN
  always_comb begin : p_arb
    logic [BtnW-1:0] cand;
    int unsigned     sum;
    cand    = '0;
    sum     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int off = 1; off <= NUM_BTN; off++) begin
      sum = 32'(last_q) + 32'(off);
      if (sum >= NUM_BTN) begin
        sum = sum - NUM_BTN;
      end
      cand = BtnW'(sum);
      if (!found && slot_vld_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign load_en = !evt_valid_q || evt.evt_ready;

  always_comb begin : p_slot
    for (int i = 0; i < NUM_BTN; i++) begin
      gnt_vec[i]     = load_en && found && (gnt_idx == BtnW'(i));
      slot_vld_d[i]  = slot_vld_q[i] && !gnt_vec[i];
      slot_type_d[i] = slot_type_q[i];
      drop[i]        = 1'b0;
      if (post_vld[i]) begin
        // A slot being granted this cycle hands out its old event, so nothing is lost
        drop[i]        = slot_vld_q[i] && !gnt_vec[i];
        slot_vld_d[i]  = 1'b1;
        slot_type_d[i] = post_type[i];
      end
    end
    dropped_d = (clr_dropped ? '0 : dropped_q) | drop;
  end

  always_comb begin : p_out
    evt_valid_d = evt_valid_q;
    evt_btn_d   = evt_btn_q;
    evt_type_d  = evt_type_q;
    last_d      = last_q;
    if (load_en) begin
      evt_valid_d = found;
      if (found) begin
        evt_btn_d  = gnt_idx;
        evt_type_d = slot_type_q[gnt_idx];
        last_d     = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pre_q       <= PreReload;
      tick_q      <= 1'b0;
      fsm_en_q    <= 1'b0;
      samp_q      <= '0;
      held_q      <= '0;
      slot_vld_q  <= '0;
      dropped_q   <= '0;
      last_q      <= BtnW'(NUM_BTN - 1);
      evt_valid_q <= 1'b0;
      evt_btn_q   <= '0;
      evt_type_q  <= EvPress;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i]     <= StIdle;
        hcnt_q[i]      <= '0;
        rcnt_q[i]      <= '0;
        slot_type_q[i] <= EvPress;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      fsm_en_q    <= fsm_en_d;
      samp_q      <= samp_d;
      held_q      <= held_d;
      slot_vld_q  <= slot_vld_d;
      dropped_q   <= dropped_d;
      last_q      <= last_d;
      evt_valid_q <= evt_valid_d;
      evt_btn_q   <= evt_btn_d;
      evt_type_q  <= evt_type_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i]     <= state_d[i];
        hcnt_q[i]      <= hcnt_d[i];
        rcnt_q[i]      <= rcnt_d[i];
        slot_type_q[i] <= slot_type_d[i];
      end
    end
  end

  assign tick          = tick_q;
  assign held          = held_q;
  assign dropped       = dropped_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_btn   = evt_btn_q;
  assign evt.evt_type  = evt_type_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a short tick period and small long/repeat counts.
// A per-tick vector table covers debounce and event generation; hand sequences cover the rest.
module tb_btn_event_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned LT = 3;
  localparam int unsigned RT = 2;
  localparam int unsigned BW = 2;
  localparam int NV = 20;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic          tick;
  logic [NB-1:0] held;
  logic [NB-1:0] dropped;
  logic          clr_dropped;

  btn_event_ctrl_if #(.BtnW(BW)) evt_if ();

  btn_event_ctrl #(
    .NUM_BTN      (NB),
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .tick        (tick),
    .held        (held),
    .evt         (evt_if),
    .dropped     (dropped),
    .clr_dropped (clr_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per tick period: btn is applied for that period; the expectations
  // describe the outcome of the tick that first samples it.
  typedef struct {
    logic [NB-1:0] btn;
    logic [NB-1:0] held;
    logic          vld;
    logic [BW-1:0] ebtn;
    logic [1:0]    etype;
  } vec_t;

  vec_t tbl [NV];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_evt(input string name, input logic [BW-1:0] b, input logic [1:0] t);
    check({name, " valid"}, 32'(evt_if.evt_valid), 32'd1);
    check({name, " btn"},   32'(evt_if.evt_btn),   32'(b));
    check({name, " type"},  32'(evt_if.evt_type),  32'(t));
  endtask

  initial begin
    // btn, held, valid, evt_btn, evt_type
    tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 2'd0};
    tbl[2]  = '{4'b0000, 4'b0010, 1'b0, 2'd0, 2'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 2'd1, 2'd1};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[9]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd0};
    tbl[10] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 2'd0};
    tbl[11] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 2'd0};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
    tbl[13] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 2'd0};
    tbl[14] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd3};
    tbl[15] = '{4'b0100, 4'b0100, 1'b0, 2'd0, 2'd0};
    tbl[16] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd3};
    tbl[17] = '{4'b0000, 4'b0100, 1'b0, 2'd0, 2'd0};
    tbl[18] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 2'd1};
    tbl[19] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};

    reset            = 1'b1;
    btn_in           = '0;
    clr_dropped      = 1'b0;
    evt_if.evt_ready = 1'b1;
    step(3);
    check("reset tick",     32'(tick),             32'd0);
    check("reset held",     32'(held),             32'd0);
    check("reset valid",    32'(evt_if.evt_valid), 32'd0);
    check("reset evt_btn",  32'(evt_if.evt_btn),   32'd0);
    check("reset evt_type", 32'(evt_if.evt_type),  32'd0);
    check("reset dropped",  32'(dropped),          32'd0);

    // Cycle 0 is the one in which reset drops; first tick lands in cycle 4
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      check($sformatf("tick cycle %0d", c), 32'(tick), (c == 4) ? 32'd1 : 32'd0);
    end

    // Buttons 0, 1, 3 together: grants follow round-robin order from button 0
    btn_in = 4'b1011;
    step(11);
    check_evt("arb press g0", 2'd0, 2'd0);
    step(1);
    check_evt("arb press g1", 2'd1, 2'd0);
    btn_in = 4'b0000;
    step(1);
    check_evt("arb press g2", 2'd3, 2'd0);
    step(1);
    check("arb press idle", 32'(evt_if.evt_valid), 32'd0);
    step(9);
    check_evt("arb rel g0", 2'd0, 2'd1);
    step(1);
    check_evt("arb rel g1", 2'd1, 2'd1);
    step(1);
    check_evt("arb rel g2", 2'd3, 2'd1);
    step(1);
    check("arb rel idle", 32'(evt_if.evt_valid), 32'd0);
    step(2);
    check("arb end tick", 32'(tick), 32'd1);

    for (int k = 0; k <= NV; k++) begin
      btn_in = (k < NV) ? tbl[k].btn : '0;
      step(3);
      if (k > 0) begin
        check($sformatf("row%0d held", k - 1),  32'(held),             32'(tbl[k-1].held));
        check($sformatf("row%0d valid", k - 1), 32'(evt_if.evt_valid), 32'(tbl[k-1].vld));
        check($sformatf("row%0d tick0", k - 1), 32'(tick),             32'd0);
        if (tbl[k-1].vld) begin
          check($sformatf("row%0d btn", k - 1),  32'(evt_if.evt_btn),  32'(tbl[k-1].ebtn));
          check($sformatf("row%0d type", k - 1), 32'(evt_if.evt_type), 32'(tbl[k-1].etype));
        end
      end
      step(1);
      check($sformatf("row%0d tick1", k), 32'(tick), 32'd1);
      check($sformatf("row%0d one-shot", k), 32'(evt_if.evt_valid), 32'd0);
    end

    // Backpressure: PRESS holds, RELEASE pends, next PRESS overwrites it
    evt_if.evt_ready = 1'b0;
    btn_in = 4'b0001;
    step(8);
    btn_in = 4'b0000;
    step(3);
    check_evt("bp press", 2'd0, 2'd0);
    step(5);
    btn_in = 4'b0001;
    step(3);
    check_evt("bp hold", 2'd0, 2'd0);
    check("bp no drop yet", 32'(dropped), 32'd0);
    step(8);
    check_evt("bp hold2", 2'd0, 2'd0);
    check("bp dropped set", 32'(dropped), 32'd1);
    clr_dropped = 1'b1;
    step(1);
    clr_dropped = 1'b0;
    check("bp dropped clr", 32'(dropped), 32'd0);
    evt_if.evt_ready = 1'b1;
    step(1);
    check_evt("bp newest wins", 2'd0, 2'd0);
    step(1);
    check("bp drained", 32'(evt_if.evt_valid), 32'd0);
    evt_if.evt_ready = 1'b0;
    step(9);
    check_evt("bp long", 2'd0, 2'd2);

    // Reset mid-operation discards the pending event; button stays high through it
    reset = 1'b1;
    step(2);
    check("midrst valid", 32'(evt_if.evt_valid), 32'd0);
    check("midrst held",   32'(held),             32'd0);
    check("midrst type",   32'(evt_if.evt_type),  32'd0);
    reset = 1'b0;
    evt_if.evt_ready = 1'b1;
    step(11);
    check_evt("post-rst press", 2'd0, 2'd0);
    check("post-rst held", 32'(held), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
